// File: rtl/pdes_pkg.sv
// Shared PDES definitions: memory-controller command encodings, request/response
// field widths and the core-index width derivation used by the MC request arbiter.
package pdes_pkg;

  localparam int MC_CMD_W  = 3;
  localparam int MC_SCMD_W = 4;
  localparam int MC_SIZE_W = 2;
  localparam int MC_VADR_W = 48;
  localparam int MC_DATA_W = 64;

  typedef enum logic [MC_CMD_W-1:0] {
    MC_CMD_IDLE   = 3'd0,
    MC_CMD_RD     = 3'd1,
    MC_CMD_WR     = 3'd2,
    MC_CMD_RD_RSP = 3'd3,
    MC_CMD_WR_RSP = 3'd4,
    MC_CMD_ATOMIC = 3'd5
  } mc_cmd_e;

  typedef enum logic [MC_SCMD_W-1:0] {
    MC_SCMD_NONE = 4'd0,
    MC_SCMD_ADD  = 4'd1,
    MC_SCMD_XCHG = 4'd2,
    MC_SCMD_CAS  = 4'd3
  } mc_scmd_e;

  typedef struct packed {
    logic [MC_CMD_W-1:0]  cmd;
    logic [MC_SCMD_W-1:0] scmd;
    logic [MC_SIZE_W-1:0] size;
    logic [MC_VADR_W-1:0] vadr;
    logic [MC_DATA_W-1:0] data;
  } mc_rq_fields_t;

  typedef struct packed {
    logic [MC_CMD_W-1:0]  cmd;
    logic [MC_SCMD_W-1:0] scmd;
    logic [MC_DATA_W-1:0] data;
  } mc_rs_fields_t;

  function automatic int core_id_wid(input int num_cores);
    return (num_cores <= 2) ? 1 : $clog2(num_cores);
  endfunction

endpackage

// File: rtl/mc_req_arbiter_rr_arb.sv
// Round-robin priority encoder: the first requester at or after the pointer wins,
// and the pointer moves to one past the winner only when a grant is issued.
module rr_arb #(
  parameter int N   = 8,
  parameter int IDW = 3
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N-1:0]   req,
  output logic [N-1:0]   gnt,
  output logic [IDW-1:0] gnt_idx,
  output logic           gnt_vld
);

  logic [IDW-1:0] ptr_q;
  logic [IDW-1:0] ptr_d;
  logic [IDW-1:0] idx;

  // Scan from farthest to nearest offset so the nearest requester is written last.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    gnt_vld = 1'b0;
    idx     = '0;
    for (int i = N - 1; i >= 0; i--) begin
      idx = ptr_q + IDW'(i);
      if (req[idx]) begin
        gnt_vld = 1'b1;
        gnt_idx = idx;
      end
    end
    if (gnt_vld) gnt[gnt_idx] = 1'b1;
    ptr_d = gnt_vld ? (gnt_idx + IDW'(1)) : ptr_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

endmodule

// File: rtl/mc_req_arbiter.sv
// Arbitrates per-core memory requests onto one MC request port and routes MC responses
// back by core index. Define MC_ARB_STATS_EN to build the arb_conflicts counter.
module mc_req_arbiter
  import pdes_pkg::*;
#(
  parameter int NUM_CORES       = 8,
  parameter int MC_RTNCTL_WIDTH = 32,
  parameter int CORE_ID_WID     = core_id_wid(NUM_CORES)
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [NUM_CORES-1:0]                 core_rq_vld,
  input  logic [NUM_CORES*MC_CMD_W-1:0]        core_rq_cmd,
  input  logic [NUM_CORES*MC_SCMD_W-1:0]       core_rq_scmd,
  input  logic [NUM_CORES*MC_SIZE_W-1:0]       core_rq_size,
  input  logic [NUM_CORES*MC_VADR_W-1:0]       core_rq_vadr,
  input  logic [NUM_CORES*MC_DATA_W-1:0]       core_rq_data,
  input  logic [NUM_CORES*MC_RTNCTL_WIDTH-1:0] core_rq_rtnctl,
  output logic [NUM_CORES-1:0]                 core_rq_gnt,
  output logic                                 mc_rq_vld,
  output logic [MC_CMD_W-1:0]                  mc_rq_cmd,
  output logic [MC_SCMD_W-1:0]                 mc_rq_scmd,
  output logic [MC_VADR_W-1:0]                 mc_rq_vadr,
  output logic [MC_SIZE_W-1:0]                 mc_rq_size,
  output logic [MC_RTNCTL_WIDTH-1:0]           mc_rq_rtnctl,
  output logic [MC_DATA_W-1:0]                 mc_rq_data,
  output logic                                 mc_rq_flush,
  input  logic                                 mc_rq_stall,
  input  logic                                 mc_rs_vld,
  input  logic [MC_CMD_W-1:0]                  mc_rs_cmd,
  input  logic [MC_SCMD_W-1:0]                 mc_rs_scmd,
  input  logic [MC_RTNCTL_WIDTH-1:0]           mc_rs_rtnctl,
  input  logic [MC_DATA_W-1:0]                 mc_rs_data,
  output logic                                 mc_rs_stall,
  output logic [NUM_CORES-1:0]                 core_rs_vld,
  output logic [MC_CMD_W-1:0]                  core_rs_cmd,
  output logic [MC_SCMD_W-1:0]                 core_rs_scmd,
  output logic [MC_RTNCTL_WIDTH-1:0]           core_rs_rtnctl,
  output logic [MC_DATA_W-1:0]                 core_rs_data,
  input  logic [NUM_CORES-1:0]                 core_rs_stall,
  output logic [63:0]                          arb_conflicts
);

  // Handshake: a core holds core_rq_vld with stable fields until it sees core_rq_gnt;
  // the MC holds mc_rq_stall while it cannot accept, and the registered request stays put.
  logic [NUM_CORES-1:0]       arb_req;
  logic [CORE_ID_WID-1:0]     win_idx;
  logic                       win_vld;
  int                         sel;

  logic                       rq_vld_q, rq_vld_d;
  mc_rq_fields_t              rq_f_q, rq_f_d;
  logic [MC_RTNCTL_WIDTH-1:0] rq_rtnctl_q, rq_rtnctl_d;
  logic [NUM_CORES-1:0]       rs_vld_q, rs_vld_d;
  mc_rs_fields_t              rs_f_q, rs_f_d;
  logic [MC_RTNCTL_WIDTH-1:0] rs_rtnctl_q, rs_rtnctl_d;

  // rst_n gates the arbiter so no grant pulse escapes while reset is held.
  assign arb_req = core_rq_vld & {NUM_CORES{rst_n & ~mc_rq_stall}};

  rr_arb #(
    .N   (NUM_CORES),
    .IDW (CORE_ID_WID)
  ) u_rr_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (arb_req),
    .gnt     (core_rq_gnt),
    .gnt_idx (win_idx),
    .gnt_vld (win_vld)
  );

  always_comb begin
    sel         = int'(win_idx);
    rq_vld_d    = rq_vld_q;
    rq_f_d      = rq_f_q;
    rq_rtnctl_d = rq_rtnctl_q;
    if (!mc_rq_stall) begin
      rq_vld_d = win_vld;
      if (win_vld) begin
        rq_f_d.cmd  = core_rq_cmd[sel*MC_CMD_W +: MC_CMD_W];
        rq_f_d.scmd = core_rq_scmd[sel*MC_SCMD_W +: MC_SCMD_W];
        rq_f_d.size = core_rq_size[sel*MC_SIZE_W +: MC_SIZE_W];
        rq_f_d.vadr = core_rq_vadr[sel*MC_VADR_W +: MC_VADR_W];
        rq_f_d.data = core_rq_data[sel*MC_DATA_W +: MC_DATA_W];
        rq_rtnctl_d = {core_rq_rtnctl[sel*MC_RTNCTL_WIDTH + CORE_ID_WID +: MC_RTNCTL_WIDTH - CORE_ID_WID],
                       win_idx};
      end
    end
  end

  always_comb begin
    rs_vld_d    = '0;
    rs_f_d      = rs_f_q;
    rs_rtnctl_d = rs_rtnctl_q;
    if (mc_rs_vld) begin
      rs_vld_d[mc_rs_rtnctl[CORE_ID_WID-1:0]] = 1'b1;
      rs_f_d      = '{cmd: mc_rs_cmd, scmd: mc_rs_scmd, data: mc_rs_data};
      rs_rtnctl_d = mc_rs_rtnctl;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rq_vld_q    <= 1'b0;
      rq_f_q      <= '0;
      rq_rtnctl_q <= '0;
      rs_vld_q    <= '0;
      rs_f_q      <= '0;
      rs_rtnctl_q <= '0;
    end else begin
      rq_vld_q    <= rq_vld_d;
      rq_f_q      <= rq_f_d;
      rq_rtnctl_q <= rq_rtnctl_d;
      rs_vld_q    <= rs_vld_d;
      rs_f_q      <= rs_f_d;
      rs_rtnctl_q <= rs_rtnctl_d;
    end
  end

  assign mc_rq_vld      = rq_vld_q;
  assign mc_rq_cmd      = rq_f_q.cmd;
  assign mc_rq_scmd     = rq_f_q.scmd;
  assign mc_rq_size     = rq_f_q.size;
  assign mc_rq_vadr     = rq_f_q.vadr;
  assign mc_rq_data     = rq_f_q.data;
  assign mc_rq_rtnctl   = rq_rtnctl_q;
  assign mc_rq_flush    = 1'b0;
  assign mc_rs_stall    = |core_rs_stall;
  assign core_rs_vld    = rs_vld_q;
  assign core_rs_cmd    = rs_f_q.cmd;
  assign core_rs_scmd   = rs_f_q.scmd;
  assign core_rs_data   = rs_f_q.data;
  assign core_rs_rtnctl = rs_rtnctl_q;

`ifdef MC_ARB_STATS_EN
  logic [63:0] conf_q, conf_d;
  logic        contended;

  // Contended: two or more requesters, or any requester held off by MC stall.
  always_comb begin
    contended = ((core_rq_vld & (core_rq_vld - NUM_CORES'(1))) != '0) ||
                ((|core_rq_vld) && mc_rq_stall);
    conf_d    = conf_q;
    if (contended && (conf_q != '1)) conf_d = conf_q + 64'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) conf_q <= '0;
    else        conf_q <= conf_d;
  end

  assign arb_conflicts = conf_q;
`else
  assign arb_conflicts = '0;
`endif

endmodule

// File: tb/tb_mc_req_arbiter.sv
// Randomized and directed bench for mc_req_arbiter against a cycle-level reference
// model of the arbitration, request-register and response-routing rules.
module tb_mc_req_arbiter;

  localparam int N   = 8;
  localparam int W   = 32;
  localparam int IDW = 3;
`ifdef MC_ARB_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [N-1:0]     core_rq_vld;
  logic [N*3-1:0]   core_rq_cmd;
  logic [N*4-1:0]   core_rq_scmd;
  logic [N*2-1:0]   core_rq_size;
  logic [N*48-1:0]  core_rq_vadr;
  logic [N*64-1:0]  core_rq_data;
  logic [N*W-1:0]   core_rq_rtnctl;
  logic [N-1:0]     core_rq_gnt;
  logic             mc_rq_vld, mc_rq_flush, mc_rq_stall;
  logic [2:0]       mc_rq_cmd;
  logic [3:0]       mc_rq_scmd;
  logic [47:0]      mc_rq_vadr;
  logic [1:0]       mc_rq_size;
  logic [W-1:0]     mc_rq_rtnctl;
  logic [63:0]      mc_rq_data;
  logic             mc_rs_vld, mc_rs_stall;
  logic [2:0]       mc_rs_cmd;
  logic [3:0]       mc_rs_scmd;
  logic [W-1:0]     mc_rs_rtnctl;
  logic [63:0]      mc_rs_data;
  logic [N-1:0]     core_rs_vld, core_rs_stall;
  logic [2:0]       core_rs_cmd;
  logic [3:0]       core_rs_scmd;
  logic [W-1:0]     core_rs_rtnctl;
  logic [63:0]      core_rs_data;
  logic [63:0]      arb_conflicts;

  mc_req_arbiter #(.NUM_CORES(N), .MC_RTNCTL_WIDTH(W), .CORE_ID_WID(IDW)) dut (
    .clk(clk), .rst_n(rst_n),
    .core_rq_vld(core_rq_vld), .core_rq_cmd(core_rq_cmd), .core_rq_scmd(core_rq_scmd),
    .core_rq_size(core_rq_size), .core_rq_vadr(core_rq_vadr), .core_rq_data(core_rq_data),
    .core_rq_rtnctl(core_rq_rtnctl), .core_rq_gnt(core_rq_gnt),
    .mc_rq_vld(mc_rq_vld), .mc_rq_cmd(mc_rq_cmd), .mc_rq_scmd(mc_rq_scmd),
    .mc_rq_vadr(mc_rq_vadr), .mc_rq_size(mc_rq_size), .mc_rq_rtnctl(mc_rq_rtnctl),
    .mc_rq_data(mc_rq_data), .mc_rq_flush(mc_rq_flush), .mc_rq_stall(mc_rq_stall),
    .mc_rs_vld(mc_rs_vld), .mc_rs_cmd(mc_rs_cmd), .mc_rs_scmd(mc_rs_scmd),
    .mc_rs_rtnctl(mc_rs_rtnctl), .mc_rs_data(mc_rs_data), .mc_rs_stall(mc_rs_stall),
    .core_rs_vld(core_rs_vld), .core_rs_cmd(core_rs_cmd), .core_rs_scmd(core_rs_scmd),
    .core_rs_rtnctl(core_rs_rtnctl), .core_rs_data(core_rs_data),
    .core_rs_stall(core_rs_stall), .arb_conflicts(arb_conflicts)
  );

  int vectors = 0;
  int miscompares = 0;

  // ---------------- reference model state ----------------
  int           m_ptr;
  logic         m_rq_vld;
  logic [2:0]   m_rq_cmd;
  logic [3:0]   m_rq_scmd;
  logic [1:0]   m_rq_size;
  logic [47:0]  m_rq_vadr;
  logic [63:0]  m_rq_data;
  logic [W-1:0] m_rq_rtnctl;
  logic [N-1:0] m_rs_vld;
  logic [2:0]   m_rs_cmd;
  logic [3:0]   m_rs_scmd;
  logic [W-1:0] m_rs_rtnctl;
  logic [63:0]  m_rs_data;
  logic [63:0]  m_conf;
  logic [N-1:0] obs_gnt, exp_gnt;
  logic         obs_rs_stall, exp_rs_stall;

  function automatic int model_pick(input logic [N-1:0] v, input int p);
    for (int k = 0; k < N; k++) if (v[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  task automatic model_reset();
    m_ptr = 0; m_rq_vld = 0; m_rq_cmd = 0; m_rq_scmd = 0; m_rq_size = 0;
    m_rq_vadr = 0; m_rq_data = 0; m_rq_rtnctl = 0; m_rs_vld = 0; m_rs_cmd = 0;
    m_rs_scmd = 0; m_rs_rtnctl = 0; m_rs_data = 0; m_conf = 0;
  endtask

  // ---------------- driver tasks ----------------
  task automatic new_req(input int i);
    core_rq_cmd[i*3 +: 3]    = 3'($urandom);
    core_rq_scmd[i*4 +: 4]   = 4'($urandom);
    core_rq_size[i*2 +: 2]   = 2'($urandom);
    core_rq_vadr[i*48 +: 48] = {16'($urandom), 32'($urandom)};
    core_rq_data[i*64 +: 64] = {32'($urandom), 32'($urandom)};
    core_rq_rtnctl[i*W +: W] = 32'($urandom);
  endtask

  // Samples combinational outputs, advances the model one clock, then steps past the edge.
  task automatic tick();
    int w;
    int nv;
    logic [W-1:0] rt;
    #1;
    obs_gnt = core_rq_gnt;
    obs_rs_stall = mc_rs_stall;
    exp_rs_stall = (core_rs_stall != 0);
    nv = $countones(core_rq_vld);
    w = mc_rq_stall ? -1 : model_pick(core_rq_vld, m_ptr);
    exp_gnt = '0;
    if (w >= 0) exp_gnt[w] = 1'b1;
    if (STATS && (nv >= 2 || (nv >= 1 && mc_rq_stall)) && m_conf != '1) m_conf = m_conf + 1;
    if (!mc_rq_stall) begin
      m_rq_vld = (w >= 0);
      if (w >= 0) begin
        m_rq_cmd  = core_rq_cmd[w*3 +: 3];
        m_rq_scmd = core_rq_scmd[w*4 +: 4];
        m_rq_size = core_rq_size[w*2 +: 2];
        m_rq_vadr = core_rq_vadr[w*48 +: 48];
        m_rq_data = core_rq_data[w*64 +: 64];
        rt = core_rq_rtnctl[w*W +: W];
        rt[IDW-1:0] = w[IDW-1:0];
        m_rq_rtnctl = rt;
        m_ptr = (w + 1) % N;
      end
    end
    m_rs_vld = '0;
    if (mc_rs_vld) begin
      m_rs_vld[int'(mc_rs_rtnctl[IDW-1:0])] = 1'b1;
      m_rs_cmd = mc_rs_cmd; m_rs_scmd = mc_rs_scmd;
      m_rs_rtnctl = mc_rs_rtnctl; m_rs_data = mc_rs_data;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    core_rq_vld = '1;
    #1;
    vectors++; if (core_rq_gnt !== 8'h00) begin miscompares++; $display("FAIL rst_gnt: got %h want 00", core_rq_gnt); end
    vectors++; if (mc_rq_vld !== 1'b0) begin miscompares++; $display("FAIL rst_rq_vld: got %b want 0", mc_rq_vld); end
    vectors++; if (core_rs_vld !== 8'h00) begin miscompares++; $display("FAIL rst_rs_vld: got %h want 00", core_rs_vld); end
    vectors++; if (mc_rq_data !== 64'h0 || mc_rq_rtnctl !== 32'h0) begin miscompares++; $display("FAIL rst_rq_data: got %h/%h want 0", mc_rq_data, mc_rq_rtnctl); end
    vectors++; if (arb_conflicts !== 64'h0) begin miscompares++; $display("FAIL rst_conflicts: got %0d want 0", arb_conflicts); end
    vectors++; if (mc_rq_flush !== 1'b0) begin miscompares++; $display("FAIL rst_flush: got %b want 0", mc_rq_flush); end
    core_rq_vld = '0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_single_core();
    core_rq_vld[3] = 1'b1;
    new_req(3);
    for (int k = 0; k < 3; k++) begin
      tick();
      vectors++; if (obs_gnt !== 8'b0000_1000) begin miscompares++; $display("FAIL single_gnt%0d: got %b want 00001000", k, obs_gnt); end
      vectors++; if (mc_rq_vld !== 1'b1) begin miscompares++; $display("FAIL single_vld%0d: got %b want 1", k, mc_rq_vld); end
      vectors++; if (mc_rq_rtnctl[IDW-1:0] !== 3'd3) begin miscompares++; $display("FAIL single_id%0d: got %0d want 3", k, mc_rq_rtnctl[IDW-1:0]); end
      vectors++; if (mc_rq_data !== m_rq_data || mc_rq_vadr !== m_rq_vadr || mc_rq_rtnctl !== m_rq_rtnctl) begin
        miscompares++; $display("FAIL single_fields%0d: got %h %h %h want %h %h %h", k, mc_rq_data, mc_rq_vadr, mc_rq_rtnctl, m_rq_data, m_rq_vadr, m_rq_rtnctl);
      end
      new_req(3);
    end
    core_rq_vld[3] = 1'b0;
    tick();
    vectors++; if (mc_rq_vld !== 1'b0) begin miscompares++; $display("FAIL single_idle: got %b want 0", mc_rq_vld); end
  endtask

  task automatic test_all_cores();
    logic [N-1:0] e;
    pulse_reset();
    core_rq_vld = '1;
    for (int i = 0; i < N; i++) new_req(i);
    for (int k = 0; k < N; k++) begin
      tick();
      e = '0; e[k] = 1'b1;
      vectors++; if (obs_gnt !== e) begin miscompares++; $display("FAIL rr_gnt%0d: got %b want %b", k, obs_gnt, e); end
      vectors++; if (mc_rq_rtnctl[IDW-1:0] !== 3'(k)) begin miscompares++; $display("FAIL rr_id%0d: got %0d want %0d", k, mc_rq_rtnctl[IDW-1:0], k); end
      core_rq_vld[k] = 1'b0;
    end
    vectors++; if (arb_conflicts !== (STATS ? 64'd7 : 64'd0)) begin miscompares++; $display("FAIL rr_conflicts: got %0d want %0d", arb_conflicts, STATS ? 7 : 0); end
    core_rq_vld[0] = 1'b1;
    new_req(0);
    tick();
    vectors++; if (obs_gnt !== 8'b0000_0001) begin miscompares++; $display("FAIL rr_wrap: got %b want 00000001", obs_gnt); end
    core_rq_vld[0] = 1'b0;
  endtask

  task automatic test_stall();
    logic [63:0] base;
    base = m_conf;
    core_rq_vld[2] = 1'b1;
    new_req(2);
    mc_rq_stall = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      vectors++; if (obs_gnt !== 8'h00) begin miscompares++; $display("FAIL stall_gnt%0d: got %b want 0", k, obs_gnt); end
      vectors++; if (mc_rq_vld !== m_rq_vld || mc_rq_data !== m_rq_data) begin miscompares++; $display("FAIL stall_hold%0d: got %b/%h want %b/%h", k, mc_rq_vld, mc_rq_data, m_rq_vld, m_rq_data); end
    end
    mc_rq_stall = 1'b0;
    tick();
    vectors++; if (obs_gnt !== 8'b0000_0100) begin miscompares++; $display("FAIL stall_release: got %b want 00000100", obs_gnt); end
    vectors++; if (mc_rq_vld !== 1'b1 || mc_rq_rtnctl[IDW-1:0] !== 3'd2) begin miscompares++; $display("FAIL stall_rq: got %b/%0d want 1/2", mc_rq_vld, mc_rq_rtnctl[IDW-1:0]); end
    vectors++; if (arb_conflicts !== base + (STATS ? 64'd5 : 64'd0)) begin miscompares++; $display("FAIL stall_conflicts: got %0d want %0d", arb_conflicts, base + (STATS ? 5 : 0)); end
    core_rq_vld[2] = 1'b0;
  endtask

  task automatic test_response();
    logic [63:0] d;
    d = {32'($urandom), 32'($urandom)};
    mc_rs_vld = 1'b1; mc_rs_rtnctl = 32'h0000_0015; mc_rs_data = d;
    mc_rs_cmd = 3'd3; mc_rs_scmd = 4'd9;
    core_rs_stall = 8'b0000_0100;
    core_rq_vld[6] = 1'b1;
    new_req(6);
    tick();
    vectors++; if (obs_rs_stall !== 1'b1) begin miscompares++; $display("FAIL rs_stall_or: got %b want 1", obs_rs_stall); end
    vectors++; if (core_rs_vld !== 8'b0010_0000) begin miscompares++; $display("FAIL rs_route: got %b want 00100000", core_rs_vld); end
    vectors++; if (core_rs_data !== d || core_rs_rtnctl !== 32'h15 || core_rs_cmd !== 3'd3 || core_rs_scmd !== 4'd9) begin
      miscompares++; $display("FAIL rs_fields: got %h %h %0d %0d want %h 15 3 9", core_rs_data, core_rs_rtnctl, core_rs_cmd, core_rs_scmd, d);
    end
    vectors++; if (mc_rq_vld !== 1'b1 || mc_rq_rtnctl[IDW-1:0] !== 3'd6) begin miscompares++; $display("FAIL rs_concurrent_rq: got %b/%0d want 1/6", mc_rq_vld, mc_rq_rtnctl[IDW-1:0]); end
    mc_rs_vld = 1'b0; core_rs_stall = '0; core_rq_vld[6] = 1'b0;
    tick();
    vectors++; if (obs_rs_stall !== 1'b0) begin miscompares++; $display("FAIL rs_stall_clear: got %b want 0", obs_rs_stall); end
    vectors++; if (core_rs_vld !== 8'h00) begin miscompares++; $display("FAIL rs_idle: got %b want 0", core_rs_vld); end
  endtask

  task automatic test_reset_mid();
    core_rq_vld[6] = 1'b1;
    new_req(6);
    tick();
    vectors++; if (mc_rq_vld !== 1'b1) begin miscompares++; $display("FAIL mid_pre: got %b want 1", mc_rq_vld); end
    core_rq_vld = 8'b1000_0010;
    new_req(1); new_req(7);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    vectors++; if (mc_rq_vld !== 1'b0 || mc_rq_data !== 64'h0) begin miscompares++; $display("FAIL mid_async: got %b/%h want 0/0", mc_rq_vld, mc_rq_data); end
    vectors++; if (core_rq_gnt !== 8'h00) begin miscompares++; $display("FAIL mid_gnt: got %b want 0", core_rq_gnt); end
    core_rq_vld = '0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    vectors++; if (mc_rq_vld !== 1'b0) begin miscompares++; $display("FAIL mid_replay: got %b want 0", mc_rq_vld); end
    core_rq_vld = 8'b1000_0010;
    tick();
    vectors++; if (obs_gnt !== 8'b0000_0010) begin miscompares++; $display("FAIL mid_first_gnt: got %b want 00000010", obs_gnt); end
    core_rq_vld[1] = 1'b0;
    tick();
    core_rq_vld[7] = 1'b0;
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      mc_rq_stall   = ($urandom_range(0, 3) == 0);
      core_rs_stall = ($urandom_range(0, 3) == 0) ? N'($urandom) : '0;
      mc_rs_vld     = 1'($urandom_range(0, 1));
      mc_rs_cmd     = 3'($urandom); mc_rs_scmd = 4'($urandom);
      mc_rs_rtnctl  = 32'($urandom); mc_rs_data = {32'($urandom), 32'($urandom)};
      tick();
      vectors++; if (obs_gnt !== exp_gnt) begin miscompares++; $display("FAIL rnd_gnt c%0d: got %b want %b", c, obs_gnt, exp_gnt); end
      vectors++; if (obs_rs_stall !== exp_rs_stall) begin miscompares++; $display("FAIL rnd_rs_stall c%0d: got %b want %b", c, obs_rs_stall, exp_rs_stall); end
      vectors++; if (mc_rq_vld !== m_rq_vld) begin miscompares++; $display("FAIL rnd_rq_vld c%0d: got %b want %b", c, mc_rq_vld, m_rq_vld); end
      if (m_rq_vld) begin
        vectors++;
        if (mc_rq_cmd !== m_rq_cmd || mc_rq_scmd !== m_rq_scmd || mc_rq_size !== m_rq_size ||
            mc_rq_vadr !== m_rq_vadr || mc_rq_data !== m_rq_data || mc_rq_rtnctl !== m_rq_rtnctl) begin
          miscompares++;
          $display("FAIL rnd_rq_fields c%0d: got %h %h %h %h %h %h want %h %h %h %h %h %h", c,
                   mc_rq_cmd, mc_rq_scmd, mc_rq_size, mc_rq_vadr, mc_rq_data, mc_rq_rtnctl,
                   m_rq_cmd, m_rq_scmd, m_rq_size, m_rq_vadr, m_rq_data, m_rq_rtnctl);
        end
      end
      vectors++; if (core_rs_vld !== m_rs_vld) begin miscompares++; $display("FAIL rnd_rs_vld c%0d: got %b want %b", c, core_rs_vld, m_rs_vld); end
      if (m_rs_vld != 0) begin
        vectors++;
        if (core_rs_cmd !== m_rs_cmd || core_rs_scmd !== m_rs_scmd || core_rs_rtnctl !== m_rs_rtnctl || core_rs_data !== m_rs_data) begin
          miscompares++; $display("FAIL rnd_rs_fields c%0d: got %h %h %h %h want %h %h %h %h", c,
                                  core_rs_cmd, core_rs_scmd, core_rs_rtnctl, core_rs_data, m_rs_cmd, m_rs_scmd, m_rs_rtnctl, m_rs_data);
        end
      end
      vectors++; if (arb_conflicts !== m_conf) begin miscompares++; $display("FAIL rnd_conflicts c%0d: got %0d want %0d", c, arb_conflicts, m_conf); end
      vectors++; if (mc_rq_flush !== 1'b0) begin miscompares++; $display("FAIL rnd_flush c%0d: got %b want 0", c, mc_rq_flush); end
      // Granted cores drop; pending cores occasionally withdraw; idle cores may raise new work.
      for (int i = 0; i < N; i++) begin
        if (obs_gnt[i] || (core_rq_vld[i] && $urandom_range(0, 15) == 0)) core_rq_vld[i] = 1'b0;
        if (!core_rq_vld[i] && $urandom_range(0, 2) == 0) begin
          core_rq_vld[i] = 1'b1;
          new_req(i);
        end
      end
    end
    mc_rq_stall = 1'b0; mc_rs_vld = 1'b0; core_rs_stall = '0; core_rq_vld = '0;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rst_n = 1'b0;
    core_rq_vld = '0; core_rq_cmd = '0; core_rq_scmd = '0; core_rq_size = '0;
    core_rq_vadr = '0; core_rq_data = '0; core_rq_rtnctl = '0;
    mc_rq_stall = 1'b0; mc_rs_vld = 1'b0; mc_rs_cmd = '0; mc_rs_scmd = '0;
    mc_rs_rtnctl = '0; mc_rs_data = '0; core_rs_stall = '0;
    model_reset();
    obs_gnt = '0; exp_gnt = '0; obs_rs_stall = 1'b0; exp_rs_stall = 1'b0;

    test_reset();
    test_single_core();
    test_all_cores();
    test_stall();
    test_response();
    test_reset_mid();
    test_random();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
